pipemdu: RTL and testbench

Multi-cycle multiply/divide unit for the 5-stage pipelined CPU. It serves MULT, MULTU, DIV and DIVU requests issued from the EXE stage and owns the HI/LO architectural registers. It also services MTHI/MTLO writes and holds HI/LO for MFHI/MFLO reads. It raises `mbusy` so the pipeline control logic stalls dependent instructions until results are committed.

---
 rtl/pipemdu_pkg.sv | 29 ++
 rtl/mdu_core.sv | 77 +++++++
 rtl/pipemdu.sv | 147 ++++++++++++++
 tb/tb_pipemdu.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipemdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op select, FSM states
// and the iteration bound of the one-bit-per-cycle datapath.
package pipemdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  localparam logic [4:0] LAST_ITER = 5'd31;

  // Bit 1 of the op code selects divide, bit 0 selects unsigned.
  function automatic logic op_is_div(input mdu_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return !op[0];
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative unsigned datapath: radix-2 shift-add multiply or restoring divide,
// one bit per step. hi/lo hold {accumulator} for multiply, {remainder, quotient} for divide.
module mdu_core
  import pipemdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_abs_i,
  input  logic [WIDTH-1:0]   b_abs_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0]   quot_o,
  output logic [WIDTH-1:0]   rem_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic             sub_ok;
  logic [WIDTH-1:0] sub_res;

  // When the shifted remainder fits, the true difference is below 2^WIDTH,
  // so a WIDTH-bit subtract is exact. A zero divisor leaves the remainder
  // equal to the dividend after all steps.
  always_comb begin
    add_sum = {1'b0, hi_q} + {1'b0, opnd_q};
    shifted = {hi_q, lo_q[WIDTH-1]};
    sub_ok  = (shifted >= {1'b0, opnd_q});
    sub_res = shifted[WIDTH-1:0] - opnd_q;
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    if (load_i) begin
      hi_d   = '0;
      lo_d   = is_div_i ? a_abs_i : b_abs_i;
      opnd_d = is_div_i ? b_abs_i : a_abs_i;
    end else if (step_i) begin
      if (is_div_i) begin
        hi_d = sub_ok ? sub_res : shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], sub_ok};
      end else if (lo_q[0]) begin
        hi_d = add_sum[WIDTH:1];
        lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
      end else begin
        hi_d = {1'b0, hi_q[WIDTH-1:1]};
        lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

  assign prod_o = {hi_q, lo_q};
  assign quot_o = lo_q;
  assign rem_o  = hi_q;

endmodule

// File: rtl/pipemdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; handles
// operand sign stripping, result sign correction and MTHI/MTLO writes.
module pipemdu
  import pipemdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             mstart,
  input  logic [1:0]       mop,
  input  logic [WIDTH-1:0] ma,
  input  logic [WIDTH-1:0] mb,
  input  logic             mwhi,
  input  logic             mwlo,
  input  logic [WIDTH-1:0] mwdata,
  output logic             mbusy,
  output logic             mdone,
  output logic [WIDTH-1:0] mhi,
  output logic [WIDTH-1:0] mlo
);

  // Handshake: mstart is accepted only while mbusy=0 (IDLE); once accepted,
  // mbusy stays high until the edge that commits HI/LO, and mdone marks the
  // first cycle the new values are visible. Inputs seen while busy are dropped.

  mdu_state_e       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             psign_q, psign_d;
  logic             rsign_q, rsign_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             mdone_q, mdone_d;

  mdu_op_e          start_op;
  logic             start_signed;
  logic [WIDTH-1:0] a_abs, b_abs;

  logic             core_load, core_step, core_is_div;
  logic [2*WIDTH-1:0] core_prod, prod_fix;
  logic [WIDTH-1:0] core_quot, core_rem, quot_fix, rem_fix;

  always_comb begin
    start_op     = mdu_op_e'(mop);
    start_signed = op_is_signed(start_op);
    a_abs        = (start_signed && ma[WIDTH-1]) ? -ma : ma;
    b_abs        = (start_signed && mb[WIDTH-1]) ? -mb : mb;
    core_is_div  = (state_q == ST_IDLE) ? op_is_div(start_op) : is_div_q;
    prod_fix     = psign_q ? -core_prod : core_prod;
    quot_fix     = psign_q ? -core_quot : core_quot;
    rem_fix      = rsign_q ? -core_rem  : core_rem;
  end

  mdu_core #(.WIDTH(WIDTH)) u_core (
    .clock    (clock),
    .resetn   (resetn),
    .load_i   (core_load),
    .step_i   (core_step),
    .is_div_i (core_is_div),
    .a_abs_i  (a_abs),
    .b_abs_i  (b_abs),
    .prod_o   (core_prod),
    .quot_o   (core_quot),
    .rem_o    (core_rem)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    psign_d   = psign_q;
    rsign_d   = rsign_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mdone_d   = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mstart) begin
          core_load = 1'b1;
          cnt_d     = '0;
          is_div_d  = op_is_div(start_op);
          psign_d   = start_signed && (ma[WIDTH-1] ^ mb[WIDTH-1]);
          rsign_d   = start_signed && ma[WIDTH-1];
          div0_d    = (mb == '0);
          state_d   = ST_CALC;
        end else begin
          if (mwhi) hi_d = mwdata;
          if (mwlo) lo_d = mwdata;
        end
      end
      ST_CALC: begin
        core_step = 1'b1;
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) state_d = ST_DONE;
      end
      ST_DONE: begin
        // With a zero divisor the core remainder is |a|, so the remainder sign
        // fix restores the raw dividend for HI.
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = div0_q ? '1 : quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        mdone_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      psign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      psign_q  <= psign_d;
      rsign_q  <= rsign_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mdone_q  <= mdone_d;
    end
  end

  assign mbusy = (state_q != ST_IDLE);
  assign mdone = mdone_q;
  assign mhi   = hi_q;
  assign mlo   = lo_q;

endmodule

// File: tb/tb_pipemdu.sv
// Directed bench for pipemdu: hand-computed HI/LO results, latency, busy/done
// timing, MT writes, ignored inputs, mid-operation reset and back-to-back issue.
module tb_pipemdu;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        mstart = 1'b0;
  logic [1:0]  mop = 2'b00;
  logic [31:0] ma = '0;
  logic [31:0] mb = '0;
  logic        mwhi = 1'b0;
  logic        mwlo = 1'b0;
  logic [31:0] mwdata = '0;
  logic        mbusy, mdone;
  logic [31:0] mhi, mlo;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int last_done_cyc = 0;

  pipemdu #(.WIDTH(32)) dut (
    .clock  (clock),
    .resetn (resetn),
    .mstart (mstart),
    .mop    (mop),
    .ma     (ma),
    .mb     (mb),
    .mwhi   (mwhi),
    .mwlo   (mwlo),
    .mwdata (mwdata),
    .mbusy  (mbusy),
    .mdone  (mdone),
    .mhi    (mhi),
    .mlo    (mlo)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    mop = op;
    ma = a;
    mb = b;
    mstart = 1'b1;
    tick();
    mstart = 1'b0;
    ma = $urandom;
    mb = $urandom;
    mop = 2'($urandom_range(0, 3));
    check("busy_after_start", {31'd0, mbusy}, 32'd1);
  endtask

  // elapsed = clock edges already taken after the start edge
  task automatic wait_result(input string tag, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input int elapsed);
    int n = elapsed;
    int busy_n = 0;
    while (!mdone && n < 100) begin
      tick();
      n++;
      if (mbusy) busy_n++;
    end
    last_done_cyc = cyc;
    check({tag, "_latency"}, n, 33);
    check({tag, "_busy_cycles"}, busy_n, 32 - elapsed);
    check({tag, "_idle_at_done"}, {31'd0, mbusy}, 32'd0);
    check({tag, "_hi"}, mhi, exp_hi);
    check({tag, "_lo"}, mlo, exp_lo);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start_op(op, a, b);
    wait_result(tag, exp_hi, exp_lo, 0);
    tick();
    check({tag, "_done_pulse"}, {31'd0, mdone}, 32'd0);
  endtask

  int done_seen;
  int t1;

  initial begin
    tick();
    tick();
    check("rst_busy", {31'd0, mbusy}, 32'd0);
    check("rst_done", {31'd0, mdone}, 32'd0);
    check("rst_hi", mhi, 32'd0);
    check("rst_lo", mlo, 32'd0);
    resetn = 1'b1;
    tick();

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu_zero", 2'b11, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
    run_op("div_zero_neg", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("divu_plain", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("multu_shift", 2'b01, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780);

    // idle MT writes
    mwhi = 1'b1;
    mwdata = 32'hDEADBEEF;
    tick();
    mwhi = 1'b0;
    check("mthi_hi", mhi, 32'hDEADBEEF);
    check("mthi_lo_kept", mlo, 32'h23456780);
    mwhi = 1'b1;
    mwlo = 1'b1;
    mwdata = 32'h0BADF00D;
    tick();
    mwhi = 1'b0;
    mwlo = 1'b0;
    check("mtboth_hi", mhi, 32'h0BADF00D);
    check("mtboth_lo", mlo, 32'h0BADF00D);

    // start wins over MTLO in the same cycle; busy-time writes and restarts dropped
    mwlo = 1'b1;
    mwdata = 32'h00005555;
    start_op(2'b01, 32'd2, 32'd3);
    mwlo = 1'b0;
    check("start_beats_mtlo", mlo, 32'h0BADF00D);
    for (int i = 0; i < 8; i++) begin
      mstart = 1'b1;
      mop = 2'b11;
      ma = 32'd99;
      mb = 32'd9;
      mwhi = 1'b1;
      mwlo = 1'b1;
      mwdata = 32'h00001111;
      tick();
    end
    mstart = 1'b0;
    mwhi = 1'b0;
    mwlo = 1'b0;
    check("busy_mt_ignored_hi", mhi, 32'h0BADF00D);
    check("busy_mt_ignored_lo", mlo, 32'h0BADF00D);
    wait_result("busy_ignore", 32'd0, 32'd6, 8);
    tick();

    // reset at edge k+10 of a MULT
    start_op(2'b00, 32'hFFFFFFFD, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("midrst_busy", {31'd0, mbusy}, 32'd0);
    check("midrst_hi", mhi, 32'd0);
    check("midrst_lo", mlo, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (mdone) done_seen++;
      tick();
    end
    check("midrst_no_done", done_seen, 0);
    run_op("after_rst", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30);

    // back-to-back: second start in the mdone cycle
    start_op(2'b11, 32'd100, 32'd7);
    wait_result("b2b_first", 32'd2, 32'd14, 0);
    t1 = last_done_cyc;
    start_op(2'b01, 32'd5, 32'd6);
    wait_result("b2b_second", 32'd0, 32'd30, 0);
    check("b2b_spacing", last_done_cyc - t1, 34);
    tick();
    check("b2b_done_pulse", {31'd0, mdone}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
